// File: rtl/tmr_seq_pkg.sv
// rtl/tmr_seq_pkg.sv - state encoding, symbols and next-state function for the TMR S1/S2 sequence recognizer
package tmr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_S1_A  = 3'd1,
        ST_S1_B  = 3'd2,
        ST_S1_C  = 3'd3,
        ST_S2_A  = 3'd4,
        ST_S2_B  = 3'd5,
        ST_S2_C  = 3'd6,
        ST_ERROR = 3'd7
    } state_t;

    localparam logic [2:0] SYM_END  = 3'd0;
    localparam logic [2:0] SYM_S1_0 = 3'd1;
    localparam logic [2:0] SYM_S1_1 = 3'd2;
    localparam logic [2:0] SYM_S1_2 = 3'd3;
    localparam logic [2:0] SYM_S2_0 = 3'd4;
    localparam logic [2:0] SYM_S2_1 = 3'd5;
    localparam logic [2:0] SYM_S2_2 = 3'd6;

    // Next state for one qualified symbol. err_exit is where ERROR leaves to.
    function automatic state_t next_state(input state_t cur, input logic [2:0] d,
                                          input state_t err_exit);
        state_t n;
        n = ST_ERROR;
        case (cur)
            ST_IDLE: begin
                if (d == SYM_S1_0)      n = ST_S1_A;
                else if (d == SYM_S2_0) n = ST_S2_A;
                else                    n = ST_IDLE;
            end
            ST_S1_A: n = (d == SYM_S1_1) ? ST_S1_B : ST_ERROR;
            ST_S1_B: n = (d == SYM_S1_2) ? ST_S1_C : ST_ERROR;
            ST_S2_A: n = (d == SYM_S2_1) ? ST_S2_B : ST_ERROR;
            ST_S2_B: n = (d == SYM_S2_2) ? ST_S2_C : ST_ERROR;
            ST_S1_C, ST_S2_C: begin
                // A completed sequence may be followed directly by a new one.
                if (d == SYM_END)       n = ST_IDLE;
                else if (d == SYM_S1_0) n = ST_S1_A;
                else if (d == SYM_S2_0) n = ST_S2_A;
                else                    n = ST_ERROR;
            end
            ST_ERROR: n = err_exit;
            default:  n = err_exit;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tmr_majority_voter.sv
// rtl/tmr_majority_voter.sv - bitwise 2-of-3 majority vote with copy-disagreement flag
module tmr_majority_voter #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] vote_o,
    output logic         mismatch_o
);

    assign vote_o     = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
    // Two comparisons suffice: if a==b and b==c then all three agree.
    assign mismatch_o = (a_i != b_i) | (b_i != c_i);

endmodule

// File: rtl/tmr_seq_fsm_ctrl.sv
// rtl/tmr_seq_fsm_ctrl.sv - triplicated S1/S2 sequence controller with scrubbing; TMR_SEQ_FAULT_INJECT_EN adds inj_stb_i/inj_sel_i/inj_mask_i
module tmr_seq_fsm_ctrl
    import tmr_seq_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter logic [2:0]  RESET_STATE_G = 3'd0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       data_i,
    input  logic             valid_i,
    input  logic             clr_cnt_i,
`ifdef TMR_SEQ_FAULT_INJECT_EN
    input  logic             inj_stb_i,
    input  logic [1:0]       inj_sel_i,
    input  logic [2:0]       inj_mask_i,
`endif
    output logic [2:0]       state_o,
    output logic             seq1_done_o,
    output logic             seq2_done_o,
    output logic             error_o,
    output logic             mismatch_o,
    output logic [CNT_W-1:0] mismatch_cnt_o
);

    logic [2:0]       r0_q;
    logic [2:0]       r1_q;
    logic [2:0]       r2_q;
    logic [2:0]       vote;
    logic             copies_differ;
    state_t           v_state;
    state_t           nxt_state;
    logic [2:0]       nxt_bits;
    logic [2:0]       flip0;
    logic [2:0]       flip1;
    logic [2:0]       flip2;
    logic             seq1_q;
    logic             seq2_q;
    logic             mm_q;
    logic [CNT_W-1:0] cnt_q;

    tmr_majority_voter #(
        .W (3)
    ) u_voter (
        .a_i        (r0_q),
        .b_i        (r1_q),
        .c_i        (r2_q),
        .vote_o     (vote),
        .mismatch_o (copies_differ)
    );

    assign v_state = state_t'(vote);

    // Without a qualified symbol every copy reloads the voted value (scrub).
    assign nxt_state = valid_i ? next_state(v_state, data_i, state_t'(RESET_STATE_G))
                               : v_state;
    assign nxt_bits  = nxt_state;

`ifdef TMR_SEQ_FAULT_INJECT_EN
    always_comb begin
        flip0 = 3'd0;
        flip1 = 3'd0;
        flip2 = 3'd0;
        if (inj_stb_i) begin
            case (inj_sel_i)
                2'd0:    flip0 = inj_mask_i;
                2'd1:    flip1 = inj_mask_i;
                2'd2:    flip2 = inj_mask_i;
                default: ;
            endcase
        end
    end
`else
    assign flip0 = 3'd0;
    assign flip1 = 3'd0;
    assign flip2 = 3'd0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r0_q   <= RESET_STATE_G;
            r1_q   <= RESET_STATE_G;
            r2_q   <= RESET_STATE_G;
            seq1_q <= 1'b0;
            seq2_q <= 1'b0;
            mm_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            r0_q   <= nxt_bits ^ flip0;
            r1_q   <= nxt_bits ^ flip1;
            r2_q   <= nxt_bits ^ flip2;
            // Pulse lands in the same cycle the voted state shows S1_C / S2_C.
            seq1_q <= valid_i && (v_state == ST_S1_B) && (nxt_state == ST_S1_C);
            seq2_q <= valid_i && (v_state == ST_S2_B) && (nxt_state == ST_S2_C);
            mm_q   <= copies_differ;
            if (clr_cnt_i) begin
                cnt_q <= '0;
            end else if (copies_differ && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign state_o        = vote;
    assign error_o        = (v_state == ST_ERROR);
    assign seq1_done_o    = seq1_q;
    assign seq2_done_o    = seq2_q;
    assign mismatch_o     = mm_q;
    assign mismatch_cnt_o = cnt_q;

endmodule

// File: tb/tb_tmr_seq_fsm_ctrl.sv
// tb/tb_tmr_seq_fsm_ctrl.sv - self-checking bench for tmr_seq_fsm_ctrl
module tb_tmr_seq_fsm_ctrl;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [2:0]       data_i;
    logic             valid_i;
    logic             clr_cnt_i;
    logic             inj_stb_i;
    logic [1:0]       inj_sel_i;
    logic [2:0]       inj_mask_i;
    logic [2:0]       state_o;
    logic             seq1_done_o;
    logic             seq2_done_o;
    logic             error_o;
    logic             mismatch_o;
    logic [CNT_W-1:0] mismatch_cnt_o;

    always #5 clk_i = ~clk_i;

    tmr_seq_fsm_ctrl #(
        .CNT_W         (CNT_W),
        .RESET_STATE_G (3'd0)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .clr_cnt_i      (clr_cnt_i),
`ifdef TMR_SEQ_FAULT_INJECT_EN
        .inj_stb_i      (inj_stb_i),
        .inj_sel_i      (inj_sel_i),
        .inj_mask_i     (inj_mask_i),
`endif
        .state_o        (state_o),
        .seq1_done_o    (seq1_done_o),
        .seq2_done_o    (seq2_done_o),
        .error_o        (error_o),
        .mismatch_o     (mismatch_o),
        .mismatch_cnt_o (mismatch_cnt_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: which sequence is in progress (0 none, 1 S1, 2 S2),
    // how many of its three symbols have been seen, and an error flag.
    int m_seq, m_pos, m_cnt;
    bit m_err, m_s1, m_s2, m_mm, m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int model_state();
        if (m_err)            return 7;
        else if (m_seq == 0)  return 0;
        else if (m_seq == 1)  return m_pos;
        else                  return 3 + m_pos;
    endfunction

    task automatic model_symbol(input int d);
        int first;
        if (m_err) begin
            m_err = 0; m_seq = 0; m_pos = 0;
        end else if (m_seq == 0 || m_pos == 3) begin
            if (d == 1)                     begin m_seq = 1; m_pos = 1; end
            else if (d == 4)                begin m_seq = 2; m_pos = 1; end
            else if (m_seq != 0 && d == 0)  begin m_seq = 0; m_pos = 0; end
            else if (m_seq != 0)            m_err = 1;
        end else begin
            first = (m_seq == 1) ? 1 : 4;
            if (d == first + m_pos) begin
                m_pos++;
                if (m_pos == 3) begin
                    if (m_seq == 1) m_s1 = 1; else m_s2 = 1;
                end
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic model_clock(input bit rst, input bit vld, input int d, input bit clr,
                               input bit istb, input int isel, input int imask);
        if (rst) begin
            m_seq = 0; m_pos = 0; m_err = 0; m_s1 = 0; m_s2 = 0;
            m_mm = 0; m_pend = 0; m_cnt = 0;
        end else begin
            m_s1 = 0; m_s2 = 0;
            m_mm = m_pend;
            if (clr) m_cnt = 0;
            else if (m_pend && m_cnt < CNT_MAX) m_cnt++;
`ifdef TMR_SEQ_FAULT_INJECT_EN
            m_pend = istb && (isel != 3) && (imask != 0);
`else
            m_pend = 0;
`endif
            if (vld) model_symbol(d);
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit vld, input int d,
                        input bit clr, input bit istb, input int isel, input int imask);
        int es;
        @(negedge clk_i);
        rst_i      = rst;
        valid_i    = vld;
        data_i     = 3'(d);
        clr_cnt_i  = clr;
        inj_stb_i  = istb;
        inj_sel_i  = 2'(isel);
        inj_mask_i = 3'(imask);
        @(posedge clk_i);
        #1;
        model_clock(rst, vld, d, clr, istb, isel, imask);
        es = model_state();
        chk({tag, " state"},    32'(state_o),        32'(es));
        chk({tag, " error"},    32'(error_o),        32'(es == 7));
        chk({tag, " seq1"},     32'(seq1_done_o),    32'(m_s1));
        chk({tag, " seq2"},     32'(seq2_done_o),    32'(m_s2));
        chk({tag, " mismatch"}, 32'(mismatch_o),     32'(m_mm));
        chk({tag, " count"},    32'(mismatch_cnt_o), 32'(m_cnt));
    endtask

    typedef struct {
        bit rst;
        bit vld;
        int d;
        int st;
        bit s1;
        bit s2;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit vld, input int d, input int st,
                       input bit s1, input bit s2);
        vec_t v;
        v.rst = rst; v.vld = vld; v.d = d; v.st = st; v.s1 = s1; v.s2 = s2;
        tbl.push_back(v);
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; data_i = 3'd0; clr_cnt_i = 1'b0;
        inj_stb_i = 1'b0; inj_sel_i = 2'd3; inj_mask_i = 3'd0;
        m_seq = 0; m_pos = 0; m_err = 0; m_s1 = 0; m_s2 = 0;
        m_mm = 0; m_pend = 0; m_cnt = 0;

        // rst, vld, data, expected state, seq1, seq2
        add(1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 2, 2, 0, 0);
        add(0, 1, 3, 3, 1, 0);
        add(0, 0, 0, 3, 0, 0);
        add(0, 1, 4, 4, 0, 0);
        add(0, 1, 5, 5, 0, 0);
        add(0, 1, 0, 7, 0, 0);
        add(0, 0, 0, 7, 0, 0);
        add(0, 1, 6, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 2, 2, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 3, 2, 0, 0);
        add(0, 1, 3, 3, 1, 0);
        add(0, 1, 4, 4, 0, 0);
        add(0, 1, 5, 5, 0, 0);
        add(0, 1, 6, 6, 0, 1);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 7, 0, 0, 0);
        add(0, 1, 4, 4, 0, 0);
        add(0, 1, 5, 5, 0, 0);
        add(1, 1, 6, 0, 0, 0);
        add(0, 1, 6, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 7, 7, 0, 0);
        add(0, 1, 3, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 2, 2, 0, 0);
        add(0, 1, 3, 3, 1, 0);
        add(0, 1, 2, 7, 0, 0);

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].vld, tbl[i].d, 0, 0, 3, 0);
            chk($sformatf("vec%0d tbl_state", i), 32'(state_o),     32'(tbl[i].st));
            chk($sformatf("vec%0d tbl_seq1", i),  32'(seq1_done_o), 32'(tbl[i].s1));
            chk($sformatf("vec%0d tbl_seq2", i),  32'(seq2_done_o), 32'(tbl[i].s2));
            chk($sformatf("vec%0d tbl_err", i),   32'(error_o),     32'(tbl[i].st == 7));
        end

`ifdef TMR_SEQ_FAULT_INJECT_EN
        // Single-copy upset in S2_A is outvoted and counted one cycle later.
        step("inj_rst", 1, 0, 0, 0, 0, 3, 0);
        step("inj_a0", 0, 1, 4, 0, 0, 3, 0);
        step("inj_a1", 0, 0, 0, 0, 1, 0, 5);
        chk("inj_a1 hold", 32'(state_o), 32'd4);
        step("inj_a2", 0, 0, 0, 0, 0, 3, 0);
        chk("inj_a2 mm", 32'(mismatch_o), 32'd1);
        chk("inj_a2 cnt", 32'(mismatch_cnt_o), 32'd1);
        step("inj_a3", 0, 0, 0, 0, 0, 3, 0);
        chk("inj_a3 scrubbed", 32'(mismatch_o), 32'd0);

        // Saturation at CNT_W=2, then clear beats a simultaneous mismatch.
        step("sat_rst", 1, 0, 0, 0, 0, 3, 0);
        step("sat_0", 0, 0, 0, 0, 1, 1, 2);
        step("sat_1", 0, 0, 0, 0, 1, 2, 1);
        chk("sat_1 cnt", 32'(mismatch_cnt_o), 32'd1);
        step("sat_2", 0, 0, 0, 0, 1, 0, 7);
        chk("sat_2 cnt", 32'(mismatch_cnt_o), 32'd2);
        step("sat_3", 0, 0, 0, 0, 1, 1, 4);
        chk("sat_3 cnt", 32'(mismatch_cnt_o), 32'd3);
        step("sat_4", 0, 0, 0, 0, 0, 3, 0);
        chk("sat_4 cnt", 32'(mismatch_cnt_o), 32'd3);
        step("sat_5", 0, 0, 0, 1, 1, 2, 3);
        chk("sat_5 clr", 32'(mismatch_cnt_o), 32'd0);
        step("sat_6", 0, 0, 0, 0, 0, 3, 0);
        chk("sat_6 cnt", 32'(mismatch_cnt_o), 32'd1);

        // Reset in S2_B with a count of 2.
        step("rb_rst", 1, 0, 0, 0, 0, 3, 0);
        step("rb_0", 0, 0, 0, 0, 1, 0, 1);
        step("rb_1", 0, 0, 0, 0, 1, 2, 6);
        step("rb_2", 0, 1, 4, 0, 0, 3, 0);
        step("rb_3", 0, 1, 5, 0, 0, 3, 0);
        chk("rb_3 state", 32'(state_o), 32'd5);
        chk("rb_3 cnt", 32'(mismatch_cnt_o), 32'd2);
        step("rb_4", 1, 1, 6, 0, 1, 1, 7);
        chk("rb_4 state", 32'(state_o), 32'd0);
        chk("rb_4 cnt", 32'(mismatch_cnt_o), 32'd0);
        chk("rb_4 pulses", 32'({seq1_done_o, seq2_done_o, mismatch_o}), 32'd0);
`endif

        // Randomised traffic biased toward valid symbols.
        step("rnd_rst", 1, 0, 0, 0, 0, 3, 0);
        for (int i = 0; i < 400; i++) begin
            bit r_rst, r_vld, r_clr, r_stb;
            int r_d;
            r_rst = ($urandom_range(0, 99) < 2);
            r_vld = ($urandom_range(0, 99) < 75);
            r_clr = ($urandom_range(0, 99) < 5);
            r_stb = ($urandom_range(0, 99) < 25);
            r_d   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                    : ((m_seq == 0 || m_pos == 3) ? (($urandom_range(0, 1) == 0) ? 1 : 4)
                       : ((m_seq == 1) ? 1 : 4) + m_pos);
            step($sformatf("rnd%0d", i), r_rst, r_vld, r_d, r_clr, r_stb,
                 $urandom_range(0, 3), $urandom_range(0, 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tmr_seq_fsm_ctrl.md
Name: tmr_seq_fsm_ctrl

Overview:
- Triplicated controller for the 8-state S1/S2 sequence-recognizer machine.
- Holds three copies of the state register and majority-votes them every cycle.
- Rewrites all three copies from the voted value each cycle, so a single-copy upset is scrubbed within one cycle.
- Reports sequence completion, protocol error, and copy-mismatch events. Sits between the link/data front end and the slow-control status registers.

Parameters:
- CNT_W, 16, width of the saturating mismatch counter (2..32).
- RESET_STATE_G, 3'd0 (IDLE), state that all copies load on reset and the state left to from ERROR.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- data_i  in  3  sequence symbol.
- valid_i  in  1  data_i is qualified this cycle.
- clr_cnt_i  in  1  synchronous clear of mismatch counter.
- state_o  out  3  voted state.
- seq1_done_o  out  1  one-cycle pulse: S1 sequence completed.
- seq2_done_o  out  1  one-cycle pulse: S2 sequence completed.
- error_o  out  1  high while state_o == ERROR.
- mismatch_o  out  1  one-cycle pulse: copies disagreed the previous cycle.
- mismatch_cnt_o  out  CNT_W  saturating mismatch count.

Behaviour:
- Only one clock and reset exist in this block: clk_i, with rst_i synchronous and active-high.
- Encoding: IDLE=0, S1_A=1, S1_B=2, S1_C=3, S2_A=4, S2_B=5, S2_C=6, ERROR=7. All 8 codes are legal, so there is no illegal-state recovery path.
- Reset (rst_i=1 at a clk_i edge):
  - all three copies <= RESET_STATE_G;
  - seq1_done_o, seq2_done_o, mismatch_o, mismatch_cnt_o <= 0;
  - error_o = 0, state_o = IDLE.
  - Reset overrides valid_i, clr_cnt_i and injection.
- Vote: v = bitwise majority(r0, r1, r2). state_o = v, and error_o = (v == ERROR); both are combinational from registers.
- Update, each non-reset cycle, for k = 0..2:
  - r_k <= ns(v, data_i) if valid_i;
  - r_k <= v otherwise (scrub).
- ns transitions:
  - IDLE: d==1 -> S1_A; d==4 -> S2_A; else IDLE.
  - S1_A: d==2 -> S1_B, else ERROR.
  - S1_B: d==3 -> S1_C, else ERROR.
  - S2_A: d==5 -> S2_B, else ERROR.
  - S2_B: d==6 -> S2_C, else ERROR.
  - S1_C and S2_C: d==0 -> IDLE; d==1 -> S1_A; d==4 -> S2_A; else ERROR.
  - ERROR -> RESET_STATE_G unconditionally. This applies only when valid_i=1; with no valid_i the machine holds ERROR.
- Done pulses (registered, aligned with state_o taking the new value):
  - seq1_done_o <= valid_i && v==S1_B && ns==S1_C.
  - seq2_done_o is the same for S2_B -> S2_C.
  - Holding in S1_C/S2_C without valid_i produces no further pulse.
- Mismatch:
  - mm = (r0!=r1)|(r1!=r2); mismatch_o <= mm (1-cycle latency).
  - Counter: clr_cnt_i -> 0 (clear wins over a simultaneous mm); else if mm and cnt != all-ones -> cnt+1; else hold. It saturates at 2^CNT_W-1 and never wraps.
- Double-copy upset: the vote follows the majority. The corrupted value is propagated into all copies and counted once. This is a documented limitation, not an error case.
- Reset mid-sequence: state_o reads IDLE on the cycle after the reset edge, and no done pulse is generated.

Optional Feature:
- Macro TMR_SEQ_FAULT_INJECT_EN.
- When defined, adds three ports:
  - inj_stb_i (1);
  - inj_sel_i (2), selecting copy 0..2 (3 = no-op);
  - inj_mask_i (3).
- On inj_stb_i, the selected copy loads (normal update value XOR inj_mask_i); the other copies update normally.
- When undefined, these ports and the injection logic do not exist.

Decomposition:
- Package tmr_seq_pkg holds the state encoding constants, the 3-bit state typedef and the ns() transition function.
- One sub-module is natural: tmr_majority_voter, a parameterised-width bitwise 2-of-3 vote that also outputs the mismatch flag.

Test Plan:
- Reset, then valid data 1,2,3 on consecutive cycles -> state_o 1,2,3; seq1_done_o is high only in the cycle state_o becomes 3; error_o stays 0.
- From IDLE, valid data 4,5,0 -> state_o 4,5,7 with error_o=1; a further valid cycle with any data -> state_o 0; with valid_i=0, state_o holds 7.
- Reach S1_B, then 5 idle cycles (valid_i=0) followed by data 3 -> state_o stays 2 while idle, then 3; exactly one seq1_done_o pulse.
- (FAULT_INJECT_EN) In S2_A, inject sel=0, mask=3'b101 -> state_o remains 4; mismatch_o=1 on the next cycle; mismatch_cnt_o=1; copies equal one cycle later.
- CNT_W=2, four single-copy injections -> mismatch_cnt_o reads 1,2,3,3. Then clr_cnt_i together with an injection -> count reads 0.
- Assert rst_i while in S2_B with a count of 2 -> next cycle state_o=0, count 0, all pulses 0.
